// File: rtl/akuma_motion_ctrl.sv
// akuma_motion_ctrl: per-frame motion and animation controller for Akuma.
// Turns debounced button levels into X/Y position, jump physics and a timed
// punch pose. It feeds the sprite selector's AkumaX, AkumaY and sprite inputs.
// State changes only on cycles where frame_tick is high. All outputs are
// registered.
// Optional build macro AKUMA_PUNCH_EDGE_EN: when it is defined, a punch starts
// only on a rising edge of btn_punch. When it is undefined, a held btn_punch
// auto-repeats.
module akuma_motion_ctrl #(
   parameter int X_INIT       = 100,
   parameter int Y_GROUND     = 300,
   parameter int X_MIN        = 0,
   parameter int X_MAX        = 560,
   parameter int WALK_STEP    = 2,
   parameter int JUMP_VEL     = 12,
   parameter int GRAVITY      = 1,
   parameter int PUNCH_FRAMES = 12
) (
   input  logic       vga_clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       btn_jump,
   input  logic       btn_punch,
   output logic [9:0] AkumaX,
   output logic [9:0] AkumaY,
   output logic [2:0] sprite,
   output logic       busy
);

   localparam int CntW = (PUNCH_FRAMES > 1) ? $clog2(PUNCH_FRAMES) : 1;

   localparam logic signed [11:0] XMinS    = 12'(X_MIN);
   localparam logic signed [11:0] XMaxS    = 12'(X_MAX);
   localparam logic signed [11:0] WalkS    = 12'(WALK_STEP);
   localparam logic signed [11:0] YGndS    = 12'(Y_GROUND);
   localparam logic signed [7:0]  JumpVelS = 8'(JUMP_VEL);
   localparam logic signed [7:0]  GravS    = 8'(GRAVITY);
   localparam logic [CntW-1:0]    CntInit  = CntW'(PUNCH_FRAMES - 1);

   localparam logic [2:0] SprStand = 3'd0;
   localparam logic [2:0] SprPunch = 3'd1;
   localparam logic [2:0] SprJump  = 3'd2;

   typedef enum logic [1:0] {StStand, StPunch, StAir} state_e;

   state_e             state_q, state_d;
   logic [9:0]         x_q, x_d;
   logic [9:0]         y_q, y_d;
   logic signed [7:0]  vy_q, vy_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2:0]         sprite_q, sprite_d;
   logic               busy_q, busy_d;
   logic               punch_start;

   // Horizontal step with clamping, shared by STAND and AIR
   logic signed [11:0] x_ext, x_step;
   logic [9:0]         x_walk;

   // One frame of vertical flight; the jump tick uses JUMP_VEL as the velocity
   logic signed [7:0]  vy_src, vy_air;
   logic signed [11:0] y_ext, y_air;
   logic [9:0]         y_air_clip;
   logic               air_land;

`ifdef AKUMA_PUNCH_EDGE_EN
   logic punch_prev_q;

   // Button level from the previous tick, used for rising-edge detection
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         punch_prev_q <= 1'b0;
      end else if (frame_tick) begin
         punch_prev_q <= btn_punch;
      end
   end

   assign punch_start = btn_punch & ~punch_prev_q;
`else
   assign punch_start = btn_punch;
`endif

   // Walk step from the left/right levels, clamped to [X_MIN, X_MAX]
   always_comb begin
      x_ext  = $signed({2'b00, x_q});
      x_step = x_ext;
      if (btn_left && !btn_right) begin
         x_step = x_ext - WalkS;
      end else if (btn_right && !btn_left) begin
         x_step = x_ext + WalkS;
      end
      if (x_step < XMinS) begin
         x_walk = 10'(X_MIN);
      end else if (x_step > XMaxS) begin
         x_walk = 10'(X_MAX);
      end else begin
         x_walk = x_step[9:0];
      end
   end

   // Airborne Y and velocity for one frame, with ground and top-of-screen limits
   always_comb begin
      vy_src     = (state_q == StAir) ? vy_q : JumpVelS;
      y_ext      = $signed({2'b00, y_q});
      y_air      = y_ext - $signed({{4{vy_src[7]}}, vy_src});
      vy_air     = vy_src - GravS;
      air_land   = (y_air >= YGndS);
      y_air_clip = (y_air < 12'sd0) ? 10'd0 : y_air[9:0];
   end

   // Next-state and registered output values
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      vy_d     = vy_q;
      cnt_d    = cnt_q;
      sprite_d = sprite_q;
      busy_d   = busy_q;

      if (frame_tick) begin
         unique case (state_q)
            StStand: begin
               if (punch_start) begin
                  state_d  = StPunch;
                  cnt_d    = CntInit;
                  sprite_d = SprPunch;
                  busy_d   = 1'b1;
               end else if (btn_jump) begin
                  // First rise is applied on the take-off tick
                  if (air_land) begin
                     y_d  = 10'(Y_GROUND);
                     vy_d = 8'sd0;
                  end else begin
                     state_d  = StAir;
                     y_d      = y_air_clip;
                     vy_d     = vy_air;
                     sprite_d = SprJump;
                     busy_d   = 1'b1;
                  end
               end else begin
                  x_d = x_walk;
               end
            end
            StPunch: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CntW'(1);
               end else begin
                  state_d  = StStand;
                  sprite_d = SprStand;
                  busy_d   = 1'b0;
               end
            end
            StAir: begin
               x_d = x_walk;
               if (air_land) begin
                  state_d  = StStand;
                  y_d      = 10'(Y_GROUND);
                  vy_d     = 8'sd0;
                  sprite_d = SprStand;
                  busy_d   = 1'b0;
               end else begin
                  y_d  = y_air_clip;
                  vy_d = vy_air;
               end
            end
            default: begin
               state_d  = StStand;
               sprite_d = SprStand;
               busy_d   = 1'b0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge vga_clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= StStand;
         x_q      <= 10'(X_INIT);
         y_q      <= 10'(Y_GROUND);
         vy_q     <= 8'sd0;
         cnt_q    <= '0;
         sprite_q <= SprStand;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         vy_q     <= vy_d;
         cnt_q    <= cnt_d;
         sprite_q <= sprite_d;
         busy_q   <= busy_d;
      end
   end

   assign AkumaX = x_q;
   assign AkumaY = y_q;
   assign sprite = sprite_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_akuma_motion_ctrl.sv
// tb_akuma_motion_ctrl: directed self-checking bench for akuma_motion_ctrl.
// A second instance starts at X=559 so that the right clamp can be reached.
module tb_akuma_motion_ctrl;

   logic       vga_clk = 1'b0;
   logic       Reset;
   logic       frame_tick;
   logic       btn_left, btn_right, btn_jump, btn_punch;
   logic [9:0] AkumaX, AkumaY;
   logic [2:0] sprite;
   logic       busy;
   logic [9:0] hi_x, hi_y;
   logic [2:0] hi_sprite;
   logic       hi_busy;

   int n_checks = 0;
   int n_fail   = 0;

   akuma_motion_ctrl u_dut (
      .vga_clk    (vga_clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_jump   (btn_jump),
      .btn_punch  (btn_punch),
      .AkumaX     (AkumaX),
      .AkumaY     (AkumaY),
      .sprite     (sprite),
      .busy       (busy)
   );

   akuma_motion_ctrl #(.X_INIT(559)) u_dut_hi (
      .vga_clk    (vga_clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .btn_jump   (btn_jump),
      .btn_punch  (btn_punch),
      .AkumaX     (hi_x),
      .AkumaY     (hi_y),
      .sprite     (hi_sprite),
      .busy       (hi_busy)
   );

   always #5 vga_clk = ~vga_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One frame tick; inputs change and outputs are sampled on falling edges
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge vga_clk);
         frame_tick = 1'b1;
         @(negedge vga_clk);
         frame_tick = 1'b0;
      end
   endtask

   initial begin
      int exp_spr;
      int n_one;

      Reset      = 1'b1;
      frame_tick = 1'b0;
      btn_left   = 1'b0;
      btn_right  = 1'b0;
      btn_jump   = 1'b0;
      btn_punch  = 1'b0;
      repeat (3) @(negedge vga_clk);
      Reset = 1'b0;
      @(negedge vga_clk);

      check_val("reset_x", AkumaX, 100);
      check_val("reset_y", AkumaY, 300);
      check_val("reset_sprite", sprite, 0);
      check_val("reset_busy", busy, 0);
      check_val("hi_reset_x", hi_x, 559);

      // Buttons between ticks are ignored
      btn_right = 1'b1;
      repeat (3) @(negedge vga_clk);
      check_val("no_tick_hold_x", AkumaX, 100);

      // Walk right; the high instance clamps at X_MAX
      tick_n(1);
      check_val("hi_clamp_x1", hi_x, 560);
      check_val("walk_x1", AkumaX, 102);
      tick_n(1);
      check_val("hi_clamp_x2", hi_x, 560);
      tick_n(3);
      check_val("walk_right5_x", AkumaX, 110);

      // Both directions pressed cancel
      btn_left = 1'b1;
      tick_n(3);
      check_val("walk_both_x", AkumaX, 110);
      btn_left  = 1'b0;
      btn_right = 1'b0;

      // Jump arc; jump is held again mid-flight and must be ignored
      btn_jump = 1'b1;
      tick_n(1);
      btn_jump = 1'b0;
      check_val("jump_t1_y", AkumaY, 288);
      check_val("jump_t1_sprite", sprite, 2);
      check_val("jump_t1_busy", busy, 1);
      tick_n(3);
      btn_jump = 1'b1;
      tick_n(4);
      btn_jump = 1'b0;
      tick_n(4);
      check_val("jump_t12_y", AkumaY, 222);
      tick_n(1);
      check_val("jump_t13_y", AkumaY, 222);
      tick_n(11);
      check_val("jump_t24_y", AkumaY, 288);
      check_val("jump_t24_sprite", sprite, 2);
      tick_n(1);
      check_val("jump_t25_y", AkumaY, 300);
      check_val("jump_t25_sprite", sprite, 0);
      check_val("jump_t25_busy", busy, 0);
      check_val("jump_x", AkumaX, 110);

      // Single punch pulse with right held: 12 punch ticks, no movement
      btn_punch = 1'b1;
      btn_right = 1'b1;
      tick_n(1);
      btn_punch = 1'b0;
      n_one = (sprite == 3'd1 && busy) ? 1 : 0;
      for (int i = 2; i <= 14; i++) begin
         tick_n(1);
         if (sprite == 3'd1 && busy) n_one++;
         if (i == 12) check_val("punch_t12_sprite", sprite, 1);
         if (i == 13) begin
            check_val("punch_t13_sprite", sprite, 0);
            check_val("punch_t13_busy", busy, 0);
            check_val("punch_t13_x", AkumaX, 110);
         end
         if (i == 14) btn_right = 1'b0;
      end
      check_val("punch_len", n_one, 12);
      check_val("punch_walk_after_x", AkumaX, 112);

      // Punch wins over jump on the same tick
      btn_punch = 1'b1;
      btn_jump  = 1'b1;
      tick_n(1);
      btn_punch = 1'b0;
      btn_jump  = 1'b0;
      check_val("pj_sprite", sprite, 1);
      check_val("pj_y", AkumaY, 300);
      tick_n(11);
      check_val("pj_t12_sprite", sprite, 1);
      tick_n(1);
      check_val("pj_t13_sprite", sprite, 0);
      check_val("pj_t13_y", AkumaY, 300);

      // Held punch for 40 ticks
      btn_punch = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick_n(1);
`ifdef AKUMA_PUNCH_EDGE_EN
         exp_spr = (k <= 12) ? 1 : 0;
`else
         exp_spr = (((k - 1) % 13) < 12) ? 1 : 0;
`endif
         check_val($sformatf("hold_k%0d_sprite", k), sprite, exp_spr);
      end
      btn_punch = 1'b0;
      tick_n(15);
      check_val("hold_end_sprite", sprite, 0);

      // Walk left down to the X_MIN clamp
      btn_left = 1'b1;
      tick_n(55);
      check_val("left_t55_x", AkumaX, 2);
      tick_n(1);
      check_val("left_t56_x", AkumaX, 0);
      tick_n(1);
      check_val("left_clamp_x", AkumaX, 0);
      btn_left = 1'b0;

      // Reset in mid-flight takes effect without a clock edge
      btn_jump = 1'b1;
      tick_n(1);
      btn_jump = 1'b0;
      tick_n(4);
      check_val("mid_jump_y", AkumaY, 250);
      @(negedge vga_clk);
      Reset = 1'b1;
      #2;
      check_val("async_rst_y", AkumaY, 300);
      check_val("async_rst_sprite", sprite, 0);
      check_val("async_rst_busy", busy, 0);
      check_val("async_rst_x", AkumaX, 100);
      @(negedge vga_clk);
      Reset = 1'b0;
      @(negedge vga_clk);
      check_val("post_rst_y", AkumaY, 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
